odd_even_sort_ctrl: RTL and testbench

Sequential odd-even transposition sorter for N unsigned W-bit elements. It sorts ascending or descending with one row of compare-swap cells reused across N phases, one phase per clock. This replaces the fully unrolled combinational sort network where area matters more than latency. Data enters and leaves through valid/ready handshakes, and the packed bus order matches the existing sort networks.

---
 rtl/odd_even_sort_ctrl.sv | 140 ++++++++++++++
 tb/tb_odd_even_sort_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/odd_even_sort_ctrl.sv
// Sequential odd-even transposition sorter: one row of compare-swap cells reused for N phases.
// Optional ODD_EVEN_SORT_EARLY_EXIT_EN: leave SORT after two consecutive swap-free phases.
module odd_even_sort_cswap #(
  parameter int W = 4
) (
  input  logic         en,
  input  logic         desc,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);
  logic swp;
  assign swp = en && (desc ? (a < b) : (a > b));
  assign lo  = swp ? b : a;
  assign hi  = swp ? a : b;
endmodule

module odd_even_sort_ctrl #(
  parameter int N = 10,
  parameter int W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [0:N*W-1]     in_data,
  input  logic               in_desc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [0:N*W-1]     out_data,
  output logic [$clog2(N):0] out_phases
);
  localparam int PW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;
  state_t state, state_nxt;

  logic [0:N-1][W-1:0] work;
  logic [W-1:0]        work_nxt [N];
  logic [W-1:0]        lo_v [N-1];
  logic [W-1:0]        hi_v [N-1];
  logic [N-2:0]        en_v;
  logic [PW-1:0]       phase;
  logic                desc_r;
  logic                exit_now;

  // Pair (p,p+1) is active on phases whose parity matches p; active pairs never overlap.
  for (genvar p = 0; p < N-1; p++) begin : g_cell
    assign en_v[p] = (p % 2 == 1) ? phase[0] : !phase[0];
    odd_even_sort_cswap #(.W(W)) u_cswap (
      .en  (en_v[p]),
      .desc(desc_r),
      .a   (work[p]),
      .b   (work[p+1]),
      .lo  (lo_v[p]),
      .hi  (hi_v[p])
    );
  end

  for (genvar i = 0; i < N; i++) begin : g_elem
    if (i == 0) begin : g_first
      assign work_nxt[i] = en_v[0] ? lo_v[0] : work[i];
    end else if (i == N-1) begin : g_last
      assign work_nxt[i] = en_v[i-1] ? hi_v[i-1] : work[i];
    end else begin : g_mid
      assign work_nxt[i] = en_v[i]   ? lo_v[i]   :
                           en_v[i-1] ? hi_v[i-1] : work[i];
    end
  end

`ifdef ODD_EVEN_SORT_EARLY_EXIT_EN
  // Equal elements never swap, so a swap happened exactly where a value moved.
  logic [N-1:0] chg;
  logic         any_swap;
  logic         quiet;
  for (genvar i = 0; i < N; i++) begin : g_chg
    assign chg[i] = (work_nxt[i] != work[i]);
  end
  assign any_swap = |chg;
  // For N=2 the odd phase has no pairs, so one quiet phase already means sorted.
  assign exit_now = (phase == PW'(N-1)) || (!any_swap && (quiet || (N == 2)));
`else
  assign exit_now = (phase == PW'(N-1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = SORT;
      SORT:    if (exit_now) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work       <= '0;
      desc_r     <= 1'b0;
      phase      <= '0;
      out_data   <= '0;
      out_phases <= '0;
`ifdef ODD_EVEN_SORT_EARLY_EXIT_EN
      quiet      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          work   <= in_data;
          desc_r <= in_desc;
          phase  <= '0;
`ifdef ODD_EVEN_SORT_EARLY_EXIT_EN
          quiet  <= 1'b0;
`endif
        end
        SORT: begin
          for (int i = 0; i < N; i++) work[i] <= work_nxt[i];
          phase <= phase + 1'b1;
`ifdef ODD_EVEN_SORT_EARLY_EXIT_EN
          quiet <= !any_swap;
`endif
          if (exit_now) begin
            for (int i = 0; i < N; i++) out_data[i*W +: W] <= work_nxt[i];
            out_phases <= phase + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_odd_even_sort_ctrl.sv
// Bench for odd_even_sort_ctrl: N=4 and N=10 instances checked against a queue-sort reference.
module tb_odd_even_sort_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_in_desc, a_out_valid, a_out_ready;
  logic [0:15] a_in_data, a_out_data;
  logic [2:0]  a_out_phases;
  logic        b_in_valid, b_in_ready, b_in_desc, b_out_valid, b_out_ready;
  logic [0:39] b_in_data, b_out_data;
  logic [4:0]  b_out_phases;

  int total = 0;
  int bad   = 0;

  odd_even_sort_ctrl #(.N(4), .W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_desc(a_in_desc), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_phases(a_out_phases));

  odd_even_sort_ctrl #(.N(10), .W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_desc(b_in_desc), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_phases(b_out_phases));

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Element 0 sits at the most significant nibble of the n*4-bit value.
  function automatic logic [39:0] ref_sort(input logic [39:0] d, input int n, input bit desc);
    int q[$];
    logic [39:0] r = '0;
    for (int i = 0; i < n; i++) q.push_back(int'(d[(n-1-i)*4 +: 4]));
    if (desc) q.rsort(); else q.sort();
    for (int i = 0; i < n; i++) r[(n-1-i)*4 +: 4] = 4'(q[i]);
    return r;
  endfunction

  function automatic int ref_phases(input logic [39:0] d, input int n, input bit desc);
`ifdef ODD_EVEN_SORT_EARLY_EXIT_EN
    int a[10];
    int ph = 0;
    bit quiet = 0;
    for (int i = 0; i < n; i++) a[i] = int'(d[(n-1-i)*4 +: 4]);
    for (int p = 0; p < n; p++) begin
      bit sw = 0;
      for (int i = p % 2; i + 1 < n; i += 2) begin
        if (desc ? (a[i] < a[i+1]) : (a[i] > a[i+1])) begin
          int t = a[i]; a[i] = a[i+1]; a[i+1] = t; sw = 1;
        end
      end
      ph = p + 1;
      if (!sw && (quiet || n == 2)) break;
      quiet = !sw;
    end
    return ph;
`else
    if (desc || d[0] || !d[0]) return n;
    return n;
`endif
  endfunction

  function automatic logic ovld(input int n);
    return (n == 4) ? a_out_valid : b_out_valid;
  endfunction
  function automatic logic rdy(input int n);
    return (n == 4) ? a_in_ready : b_in_ready;
  endfunction
  function automatic logic [39:0] odat(input int n);
    return (n == 4) ? {24'b0, a_out_data} : 40'(b_out_data);
  endfunction
  function automatic logic [39:0] ophs(input int n);
    return (n == 4) ? 40'(a_out_phases) : 40'(b_out_phases);
  endfunction

  task automatic set_in(input int n, input logic v, input logic [39:0] d, input logic desc);
    if (n == 4) begin a_in_valid = v; a_in_data = d[15:0]; a_in_desc = desc; end
    else        begin b_in_valid = v; b_in_data = d;       b_in_desc = desc; end
  endtask
  task automatic set_ordy(input int n, input logic r);
    if (n == 4) a_out_ready = r; else b_out_ready = r;
  endtask

  task automatic run(input int n, input logic [39:0] d, input bit desc, input int hold);
    logic [39:0] ed;
    int ep, cyc;
    ed = ref_sort(d, n, desc);
    ep = ref_phases(d, n, desc);
    set_in(n, 1'b1, d, desc);
    check("in_ready_idle", 40'(rdy(n)), 40'd1);
    @(posedge clk); #1;
    // Scramble inputs after accept; out_ready pulsed during SORT must be ignored.
    set_in(n, 1'b0, ~d, ~desc);
    set_ordy(n, 1'b1);
    @(posedge clk); #1;
    set_ordy(n, 1'b0);
    cyc = 1;
    while (!ovld(n) && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 40'(cyc), 40'(ep));
    check("out_data", odat(n), ed);
    check("out_phases", ophs(n), 40'(ep));
    check("in_ready_done", 40'(rdy(n)), 40'd0);
    repeat (hold) begin
      set_in(n, 1'b1, d ^ 40'h5, desc);
      @(posedge clk); #1;
      check("hold_valid", 40'(ovld(n)), 40'd1);
      check("hold_data", odat(n), ed);
      check("hold_ready", 40'(rdy(n)), 40'd0);
    end
    set_in(n, 1'b0, d, desc);
    set_ordy(n, 1'b1);
    @(posedge clk); #1;
    set_ordy(n, 1'b0);
    check("release_valid", 40'(ovld(n)), 40'd0);
    check("release_ready", 40'(rdy(n)), 40'd1);
    check("release_data", odat(n), ed);
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(4, 1'b0, '0, 1'b0);
    set_in(10, 1'b0, '0, 1'b0);
    set_ordy(4, 1'b0);
    set_ordy(10, 1'b0);
    #12;
    check("rst_a_valid", 40'(a_out_valid), 40'd0);
    check("rst_a_ready", 40'(a_in_ready), 40'd1);
    check("rst_a_data", 40'(a_out_data), 40'd0);
    check("rst_a_phases", 40'(a_out_phases), 40'd0);
    check("rst_b_ready", 40'(b_in_ready), 40'd1);
    check("rst_b_data", 40'(b_out_data), 40'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(4, 40'h3120, 1'b0, 0);
    check("plan_asc", odat(4), 40'h0123);
    run(4, 40'h3120, 1'b1, 0);
    check("plan_desc", odat(4), 40'h3210);
    run(10, 40'h9876543210, 1'b0, 0);
    check("plan_n10", odat(10), 40'h0123456789);
    run(4, 40'hF0F0, 1'b0, 0);
    check("plan_dup", odat(4), 40'h00FF);
    run(4, 40'h2222, 1'b0, 0);
    run(4, 40'h2222, 1'b1, 0);
    check("plan_equal", odat(4), 40'h2222);
    run(4, 40'h3120, 1'b0, 7);
    run(4, 40'h0123, 1'b0, 0);
    run(4, 40'h3210, 1'b0, 0);
    run(10, 40'h0123456789, 1'b1, 2);

    for (int k = 0; k < 12; k++)
      run(4, 40'($urandom_range(0, 16'hFFFF)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    for (int k = 0; k < 12; k++)
      run(10, {8'($urandom), 32'($urandom)}, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));

    // Async reset in the middle of a sort, between clock edges.
    set_in(4, 1'b1, 40'h3120, 1'b0);
    @(posedge clk); #1;
    set_in(4, 1'b0, 40'h0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_valid", 40'(a_out_valid), 40'd0);
    check("midrst_ready", 40'(a_in_ready), 40'd1);
    check("midrst_data", 40'(a_out_data), 40'd0);
    check("midrst_phases", 40'(a_out_phases), 40'd0);
    check("midrst_b_data", 40'(b_out_data), 40'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    run(4, 40'h1302, 1'b0, 0);
    check("post_rst", odat(4), 40'h0123);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
